// File: rtl/cpu_lockstep_checker.sv
// cpu_lockstep_checker: compares reference and DUV retirement records in program order through per-side FIFOs
// Ports:
//   clk, rst_n                       clock shared by both CPU paths, async active-low reset
//   enable_i, clear_i                checking enable, synchronous flush of FIFOs, counters and flags
//   ref_retire_i, ref_*_i            reference retire pulse plus {opcode,A,X,Y} after that instruction
//   duv_retire_i, duv_*_i            DUV retire pulse plus {opcode,A,X,Y}
//   match_cnt_o, mismatch_cnt_o      saturating compare counters
//   error_o, first_err_*_o           sticky mismatch flag and capture of the first failing compare
//   overflow_o, timeout_o            sticky FIFO overflow and skew timeout
//   state_o                          0 IDLE, 1 RUN, 2 HALT
module cpu_lockstep_checker #(
    parameter int DEPTH       = 8,
    parameter int MAX_SKEW    = 64,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable_i,
    input  logic        clear_i,
    input  logic        ref_retire_i,
    input  logic [7:0]  ref_opcode_i,
    input  logic [7:0]  ref_a_i,
    input  logic [7:0]  ref_x_i,
    input  logic [7:0]  ref_y_i,
    input  logic        duv_retire_i,
    input  logic [7:0]  duv_opcode_i,
    input  logic [7:0]  duv_a_i,
    input  logic [7:0]  duv_x_i,
    input  logic [7:0]  duv_y_i,
    output logic [15:0] match_cnt_o,
    output logic [15:0] mismatch_cnt_o,
    output logic        error_o,
    output logic [15:0] first_err_idx_o,
    output logic [7:0]  first_err_opcode_o,
    output logic [3:0]  first_err_field_o,
    output logic        overflow_o,
    output logic        timeout_o,
    output logic [1:0]  state_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(MAX_SKEW + 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HALT = 2'd2;

    logic [31:0]   ref_mem [DEPTH];
    logic [31:0]   duv_mem [DEPTH];
    logic [AW:0]   ref_wp, ref_rp, duv_wp, duv_rp;
    logic [SW-1:0] skew;
    logic [15:0]   total;
    logic          ref_empty, duv_empty, ref_full, duv_full;
    logic          act, do_cmp, ref_push, duv_push, ovf, skew_on, to_hit, mism;
    logic [31:0]   ref_head, duv_head;
    logic [3:0]    diff;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        ref_empty = ref_wp == ref_rp;
        duv_empty = duv_wp == duv_rp;
        ref_full  = (ref_wp - ref_rp) == (AW+1)'(DEPTH);
        duv_full  = (duv_wp - duv_rp) == (AW+1)'(DEPTH);
        act       = state_o == RUN && enable_i && !clear_i;
        do_cmp    = act && !ref_empty && !duv_empty;
        // A push into a full FIFO is legal only when the same edge pops it.
        ref_push  = act && ref_retire_i && (!ref_full || do_cmp);
        duv_push  = act && duv_retire_i && (!duv_full || do_cmp);
        ovf       = act && ((ref_retire_i && ref_full && !do_cmp) || (duv_retire_i && duv_full && !do_cmp));
        skew_on   = ref_empty != duv_empty;
        to_hit    = act && skew_on && skew == SW'(MAX_SKEW - 1);
        ref_head  = ref_mem[ref_rp[AW-1:0]];
        duv_head  = duv_mem[duv_rp[AW-1:0]];
        diff      = {ref_head[31:24] != duv_head[31:24], ref_head[23:16] != duv_head[23:16],
                     ref_head[15:8] != duv_head[15:8], ref_head[7:0] != duv_head[7:0]};
        mism      = do_cmp && diff != 4'b0;
    end

    always_ff @(posedge clk) begin
        if (ref_push) ref_mem[ref_wp[AW-1:0]] <= {ref_opcode_i, ref_a_i, ref_x_i, ref_y_i};
        if (duv_push) duv_mem[duv_wp[AW-1:0]] <= {duv_opcode_i, duv_a_i, duv_x_i, duv_y_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || clear_i) begin
            ref_wp             <= '0;
            ref_rp             <= '0;
            duv_wp             <= '0;
            duv_rp             <= '0;
            skew               <= '0;
            total              <= '0;
            match_cnt_o        <= '0;
            mismatch_cnt_o     <= '0;
            error_o            <= 1'b0;
            first_err_idx_o    <= '0;
            first_err_opcode_o <= '0;
            first_err_field_o  <= '0;
            overflow_o         <= 1'b0;
            timeout_o          <= 1'b0;
            state_o            <= IDLE;
        end else if (act) begin
            ref_wp <= ref_wp + (AW+1)'(ref_push);
            duv_wp <= duv_wp + (AW+1)'(duv_push);
            skew   <= skew_on ? skew + SW'(1) : '0;
            if (do_cmp) begin
                ref_rp <= ref_rp + (AW+1)'(1);
                duv_rp <= duv_rp + (AW+1)'(1);
                total  <= total + 16'(total != 16'hFFFF);
                if (mism) begin
                    mismatch_cnt_o <= mismatch_cnt_o + 16'(mismatch_cnt_o != 16'hFFFF);
                    if (!error_o) begin
                        error_o            <= 1'b1;
                        first_err_idx_o    <= total;
                        first_err_opcode_o <= ref_head[31:24];
                        first_err_field_o  <= diff;
                    end
                end else begin
                    match_cnt_o <= match_cnt_o + 16'(match_cnt_o != 16'hFFFF);
                end
            end
            if (ovf) overflow_o <= 1'b1;
            if (to_hit) timeout_o <= 1'b1;
            if (ovf || to_hit || (mism && STOP_ON_ERR)) state_o <= HALT;
        end else if (state_o == RUN) begin
            state_o <= IDLE;
        end else if (state_o == IDLE && enable_i) begin
            state_o <= RUN;
        end
    end
endmodule

// File: tb/tb_cpu_lockstep_checker.sv
// tb_cpu_lockstep_checker: scoreboard bench for cpu_lockstep_checker with default parameters
module tb_cpu_lockstep_checker;
    logic        clk = 1'b0, rst_n = 1'b0, enable_i = 1'b0, clear_i = 1'b0;
    logic        ref_retire_i = 1'b0, duv_retire_i = 1'b0;
    logic [7:0]  ref_opcode_i = '0, ref_a_i = '0, ref_x_i = '0, ref_y_i = '0;
    logic [7:0]  duv_opcode_i = '0, duv_a_i = '0, duv_x_i = '0, duv_y_i = '0;
    logic [15:0] match_cnt_o, mismatch_cnt_o, first_err_idx_o;
    logic        error_o, overflow_o, timeout_o;
    logic [7:0]  first_err_opcode_o;
    logic [3:0]  first_err_field_o;
    logic [1:0]  state_o;

    int          checks = 0, errors = 0;
    bit          sb_on = 1'b0;
    logic [31:0] mref[$], mduv[$];
    logic [12:0] exp_q[$];
    logic [15:0] prev_mc = '0, prev_mm = '0;

    cpu_lockstep_checker dut (
        .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .clear_i(clear_i),
        .ref_retire_i(ref_retire_i), .ref_opcode_i(ref_opcode_i), .ref_a_i(ref_a_i), .ref_x_i(ref_x_i), .ref_y_i(ref_y_i),
        .duv_retire_i(duv_retire_i), .duv_opcode_i(duv_opcode_i), .duv_a_i(duv_a_i), .duv_x_i(duv_x_i), .duv_y_i(duv_y_i),
        .match_cnt_o(match_cnt_o), .mismatch_cnt_o(mismatch_cnt_o), .error_o(error_o),
        .first_err_idx_o(first_err_idx_o), .first_err_opcode_o(first_err_opcode_o), .first_err_field_o(first_err_field_o),
        .overflow_o(overflow_o), .timeout_o(timeout_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Scoreboard consumer: every counter increment pops the oldest predicted compare outcome.
    always @(negedge clk) begin
        if (sb_on && rst_n) begin
            if (match_cnt_o == prev_mc + 16'd1) begin
                checks++;
                if (exp_q.size() == 0 || exp_q[0][12] !== 1'b0) begin
                    errors++;
                    $display("FAIL sb_match: dut counted match %0d, expected entry=%h (queue size %0d, need a match entry)",
                             match_cnt_o, exp_q.size() > 0 ? exp_q[0] : 13'h0, exp_q.size());
                end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (mismatch_cnt_o == prev_mm + 16'd1) begin
                checks++;
                if (exp_q.size() == 0 || exp_q[0][12] !== 1'b1) begin
                    errors++;
                    $display("FAIL sb_mismatch: dut counted mismatch %0d, expected entry=%h (queue size %0d, need a mismatch entry)",
                             mismatch_cnt_o, exp_q.size() > 0 ? exp_q[0] : 13'h0, exp_q.size());
                end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
        end
        prev_mc = match_cnt_o;
        prev_mm = mismatch_cnt_o;
    end

    task automatic step(input logic rv, input logic [31:0] rr, input logic dv, input logic [31:0] dr);
        logic [31:0] a, b;
        logic [3:0]  d;
        ref_retire_i = rv;
        {ref_opcode_i, ref_a_i, ref_x_i, ref_y_i} = rr;
        duv_retire_i = dv;
        {duv_opcode_i, duv_a_i, duv_x_i, duv_y_i} = dr;
        if (sb_on) begin
            if (rv) mref.push_back(rr);
            if (dv) mduv.push_back(dr);
            while (mref.size() > 0 && mduv.size() > 0) begin
                a = mref.pop_front();
                b = mduv.pop_front();
                d = {a[31:24] != b[31:24], a[23:16] != b[23:16], a[15:8] != b[15:8], a[7:0] != b[7:0]};
                exp_q.push_back({|d, d, a[31:24]});
            end
        end
        @(negedge clk);
        ref_retire_i = 1'b0;
        duv_retire_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        mref.delete();
        mduv.delete();
        exp_q.delete();
        @(negedge clk);
        clear_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        enable_i = 1'b1;
        idle(2);
        checks++;
        if ({match_cnt_o, mismatch_cnt_o, error_o, first_err_idx_o, first_err_opcode_o, first_err_field_o,
             overflow_o, timeout_o, state_o} !== 65'b0) begin
            errors++;
            $display("FAIL reset_outputs: got match=%0d mism=%0d err=%b ovf=%b to=%b state=%0d, required all 0",
                     match_cnt_o, mismatch_cnt_o, error_o, overflow_o, timeout_o, state_o);
        end
        rst_n = 1'b1;
        idle(1);
        checks++;
        if (state_o !== 2'd1) begin errors++; $display("FAIL reset_to_run: state=%0d required 1", state_o); end
    endtask

    task automatic test_lockstep();
        logic [31:0] r;
        sb_on = 1'b1;
        do_clear();
        for (int i = 0; i < 100; i++) begin
            r = $urandom;
            step(1'b1, r, 1'b1, r);
        end
        checks++;
        if (match_cnt_o !== 16'd99) begin errors++; $display("FAIL lockstep_latency: match=%0d required 99", match_cnt_o); end
        idle(1);
        checks++;
        if (match_cnt_o !== 16'd100) begin errors++; $display("FAIL lockstep_match: match=%0d required 100", match_cnt_o); end
        checks++;
        if (mismatch_cnt_o !== 16'd0 || error_o !== 1'b0) begin
            errors++;
            $display("FAIL lockstep_clean: mism=%0d err=%b required 0 0", mismatch_cnt_o, error_o);
        end
        idle(1);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL lockstep_drain: %0d predicted compares missing, required 0", exp_q.size()); end
    endtask

    task automatic test_lag();
        logic [31:0] rec [20];
        do_clear();
        for (int i = 0; i < 20; i++) rec[i] = $urandom;
        for (int i = 0; i < 5; i++) step(1'b1, rec[i], 1'b0, 32'h0);
        for (int i = 5; i < 20; i++) step(1'b1, rec[i], 1'b1, rec[i-5]);
        for (int i = 15; i < 20; i++) step(1'b0, 32'h0, 1'b1, rec[i]);
        idle(70);
        checks++;
        if (match_cnt_o !== 16'd20 || mismatch_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL lag_counts: match=%0d mism=%0d required 20 0", match_cnt_o, mismatch_cnt_o);
        end
        checks++;
        if (timeout_o !== 1'b0 || state_o !== 2'd1) begin
            errors++;
            $display("FAIL lag_no_timeout: timeout=%b state=%0d required 0 1", timeout_o, state_o);
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL lag_drain: %0d predicted compares missing, required 0", exp_q.size()); end
    endtask

    task automatic test_full_pushpop();
        logic [31:0] rec [12];
        do_clear();
        for (int i = 0; i < 12; i++) rec[i] = $urandom;
        for (int i = 0; i < 8; i++) step(1'b1, rec[i], 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b1, rec[0]);
        for (int i = 8; i < 12; i++) step(1'b1, rec[i], 1'b1, rec[i-7]);
        for (int i = 5; i < 12; i++) step(1'b0, 32'h0, 1'b1, rec[i]);
        idle(3);
        checks++;
        if (overflow_o !== 1'b0 || state_o !== 2'd1) begin
            errors++;
            $display("FAIL full_pushpop_no_ovf: overflow=%b state=%0d required 0 1", overflow_o, state_o);
        end
        checks++;
        if (match_cnt_o !== 16'd12 || mismatch_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL full_pushpop_counts: match=%0d mism=%0d required 12 0", match_cnt_o, mismatch_cnt_o);
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL full_pushpop_drain: %0d predicted compares missing, required 0", exp_q.size()); end
    endtask

    task automatic test_mismatch();
        logic [31:0] r, d;
        do_clear();
        for (int i = 0; i < 12; i++) begin
            r = $urandom;
            if (i == 7) begin r[31:24] = 8'hE8; r[15:8] = 8'h40; end
            if (i == 10) r[31:24] = 8'h10;
            d = r;
            if (i == 7) d[15:8] = 8'h41;
            if (i == 10) d[23:16] = ~r[23:16];
            step(1'b1, r, 1'b1, d);
        end
        idle(3);
        checks++;
        if (error_o !== 1'b1 || first_err_idx_o !== 16'd7) begin
            errors++;
            $display("FAIL mismatch_first_idx: err=%b idx=%0d required 1 7", error_o, first_err_idx_o);
        end
        checks++;
        if (first_err_opcode_o !== 8'hE8 || first_err_field_o !== 4'b0010) begin
            errors++;
            $display("FAIL mismatch_first_rec: opcode=%h field=%b required e8 0010", first_err_opcode_o, first_err_field_o);
        end
        checks++;
        if (mismatch_cnt_o !== 16'd2 || match_cnt_o !== 16'd10 || state_o !== 2'd1) begin
            errors++;
            $display("FAIL mismatch_counts: mism=%0d match=%0d state=%0d required 2 10 1", mismatch_cnt_o, match_cnt_o, state_o);
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL mismatch_drain: %0d predicted compares missing, required 0", exp_q.size()); end
    endtask

    task automatic test_overflow();
        sb_on = 1'b0;
        do_clear();
        for (int i = 0; i < 8; i++) step(1'b1, $urandom, 1'b0, 32'h0);
        checks++;
        if (overflow_o !== 1'b0 || state_o !== 2'd1) begin
            errors++;
            $display("FAIL overflow_at_full: overflow=%b state=%0d required 0 1", overflow_o, state_o);
        end
        step(1'b1, $urandom, 1'b0, 32'h0);
        checks++;
        if (overflow_o !== 1'b1 || state_o !== 2'd2) begin
            errors++;
            $display("FAIL overflow_set: overflow=%b state=%0d required 1 2", overflow_o, state_o);
        end
        for (int i = 0; i < 4; i++) step(1'b1, 32'h55, 1'b1, 32'h55);
        idle(80);
        checks++;
        if (match_cnt_o !== 16'd0 || mismatch_cnt_o !== 16'd0 || timeout_o !== 1'b0 || state_o !== 2'd2) begin
            errors++;
            $display("FAIL overflow_frozen: match=%0d mism=%0d timeout=%b state=%0d required 0 0 0 2",
                     match_cnt_o, mismatch_cnt_o, timeout_o, state_o);
        end
    endtask

    task automatic test_timeout();
        do_clear();
        step(1'b1, $urandom, 1'b0, 32'h0);
        idle(63);
        checks++;
        if (timeout_o !== 1'b0) begin errors++; $display("FAIL timeout_early: timeout=%b after 63 cycles required 0", timeout_o); end
        idle(1);
        checks++;
        if (timeout_o !== 1'b1 || state_o !== 2'd2) begin
            errors++;
            $display("FAIL timeout_at_64: timeout=%b state=%0d required 1 2", timeout_o, state_o);
        end
    endtask

    task automatic test_reset_clear();
        do_clear();
        step(1'b1, 32'h11223344, 1'b1, 32'h11223345);
        step(1'b1, 32'h01020304, 1'b0, 32'h0);
        checks++;
        if (error_o !== 1'b1) begin errors++; $display("FAIL midrun_error: err=%b required 1", error_o); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({match_cnt_o, mismatch_cnt_o, error_o, first_err_idx_o, first_err_opcode_o, first_err_field_o,
             overflow_o, timeout_o, state_o} !== 65'b0) begin
            errors++;
            $display("FAIL async_reset: mism=%0d err=%b idx=%0d op=%h field=%b state=%0d required all 0",
                     mismatch_cnt_o, error_o, first_err_idx_o, first_err_opcode_o, first_err_field_o, state_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        step(1'b1, 32'hA0A0A0A0, 1'b1, 32'hA0A0A0A1);
        idle(1);
        checks++;
        if (error_o !== 1'b1 || mismatch_cnt_o !== 16'd1) begin
            errors++;
            $display("FAIL pre_clear_error: err=%b mism=%0d required 1 1", error_o, mismatch_cnt_o);
        end
        clear_i = 1'b1;
        step(1'b1, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D);
        clear_i = 1'b0;
        checks++;
        if ({match_cnt_o, mismatch_cnt_o, error_o, first_err_idx_o, first_err_opcode_o, first_err_field_o,
             overflow_o, timeout_o, state_o} !== 65'b0) begin
            errors++;
            $display("FAIL clear_outputs: match=%0d mism=%0d err=%b field=%b state=%0d required all 0",
                     match_cnt_o, mismatch_cnt_o, error_o, first_err_field_o, state_o);
        end
        idle(70);
        checks++;
        if (match_cnt_o !== 16'd0 || mismatch_cnt_o !== 16'd0 || timeout_o !== 1'b0 || state_o !== 2'd1) begin
            errors++;
            $display("FAIL clear_no_push: match=%0d mism=%0d timeout=%b state=%0d required 0 0 0 1",
                     match_cnt_o, mismatch_cnt_o, timeout_o, state_o);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_lockstep();
        test_lag();
        test_full_pushpop();
        test_mismatch();
        test_overflow();
        test_timeout();
        test_reset_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
